// File: rtl/lc3b_ctypes.sv
// Cache-specific types: controller state encoding and address field widths as functions of SETS.
package lc3b_ctypes;

  localparam int OFFSET_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } cache_state_e;

  function automatic int index_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int sets);
    return 16 - OFFSET_W - $clog2(sets);
  endfunction

endpackage

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: cache line, byte-lane write mask and CPU word.
package lc3b_types;

  typedef logic [127:0] lc3b_cline;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [15:0]  lc3b_word;

endpackage

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU: WAYS-1 bits per set, heap-ordered, a bit of 0 points the victim left.
module cache_plru #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(SETS)-1:0]   i_index,
  input  logic                      i_update,
  input  logic [$clog2(WAYS)-1:0]   i_way,
  output logic [$clog2(WAYS)-1:0]   o_victim
);

  localparam int LVL = $clog2(WAYS);

  logic [WAYS-2:0] r_bits [SETS];
  logic [WAYS-2:0] w_cur;
  logic [WAYS-2:0] w_next;

  assign w_cur = r_bits[i_index];

  // Walk from the root following the stored direction bits down to a leaf.
  always_comb begin
    int  node;
    logic dir;
    node     = 1;
    dir      = 1'b0;
    o_victim = '0;
    for (int l = 0; l < LVL; l++) begin
      dir = 1'b0;
      for (int n = 0; n < WAYS - 1; n++)
        if (n + 1 == node) dir = w_cur[n];
      node = 2 * node + (dir ? 1 : 0);
    end
    o_victim = LVL'(node - WAYS);
  end

  // Point every node on the accessed way's path toward the opposite subtree.
  always_comb begin
    int  node;
    logic d;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_next = w_cur;
    node   = 1;
    d      = 1'b0;
    for (int l = 0; l < LVL; l++) begin
      d = i_way[LVL-1-l];
      for (int n = 0; n < WAYS - 1; n++)
        if (n + 1 == node) w_next[n] = ~d;
      node = 2 * node + (d ? 1 : 0);
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) r_bits[s] <= '0;
    end else if (i_update) begin
      r_bits[i_index] <= w_next;
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back cache with tree PLRU replacement and an IDLE/WRITEBACK/FILL controller.
// Optional performance counters are built when CACHE_PERF_CNT_EN is defined.
module cache_nway
  import lc3b_types::*;
  import lc3b_ctypes::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [1:0]    mem_byte_enable,
  input  logic [15:0]   mem_wdata,
  output logic [15:0]   mem_rdata,
  output logic          mem_resp,
  output logic [15:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  input  logic [127:0]  pmem_rdata,
  output logic [127:0]  pmem_wdata,
  input  logic          pmem_resp,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count,
  output logic [15:0]   wb_count
);

  localparam int IW = index_width(SETS);
  localparam int TW = tag_width(SETS);
  localparam int WW = $clog2(WAYS);

  cache_state_e    r_state, w_state_nxt;
  lc3b_cline       r_data  [WAYS][SETS];
  logic [TW-1:0]   r_tag   [WAYS][SETS];
  logic [SETS-1:0] r_valid [WAYS];
  logic [SETS-1:0] r_dirty [WAYS];
  logic [WW-1:0]   r_victim;
  logic [11:0]     r_line;

  logic [TW-1:0] w_tag, w_r_tag;
  logic [IW-1:0] w_index, w_r_idx;
  logic [2:0]    w_off;
  logic          w_hit, w_inv, w_req, w_hit_resp, w_miss, w_fill_done, w_victim_dirty;
  logic [WW-1:0] w_hit_way, w_inv_way, w_plru_victim, w_victim_sel;
  lc3b_cline     w_hit_line;
  logic [15:0]   w_merged;
  logic          w_unused;

  assign w_tag    = mem_address[15 -: TW];
  assign w_index  = mem_address[OFFSET_W +: IW];
  assign w_off    = mem_address[3:1];
  assign w_r_tag  = r_line[11 -: TW];
  assign w_r_idx  = r_line[IW-1:0];
  assign w_unused = mem_address[0];

  // Descending scan so the lowest-numbered matching / invalid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w][w_index] && r_tag[w][w_index] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(w);
      end
      if (!r_valid[w][w_index]) begin
        w_inv     = 1'b1;
        w_inv_way = WW'(w);
      end
    end
  end

  assign w_req          = mem_read | mem_write;
  assign w_hit_resp     = (r_state == IDLE) && w_req && w_hit;
  assign w_miss         = (r_state == IDLE) && w_req && !w_hit;
  assign w_fill_done    = (r_state == FILL) && pmem_resp;
  assign w_victim_sel   = w_inv ? w_inv_way : w_plru_victim;
  assign w_victim_dirty = r_valid[w_victim_sel][w_index] && r_dirty[w_victim_sel][w_index];

  assign w_hit_line = r_data[w_hit_way][w_index];
  assign mem_rdata  = w_hit_line[{w_off, 4'h0} +: 16];
  assign mem_resp   = w_hit_resp;
  assign w_merged   = {mem_byte_enable[1] ? mem_wdata[15:8] : mem_rdata[15:8],
                       mem_byte_enable[0] ? mem_wdata[7:0]  : mem_rdata[7:0]};
  assign pmem_wdata = r_data[r_victim][w_r_idx];

  cache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_index  (w_index),
    .i_update (w_hit_resp),
    .i_way    (w_hit_way),
    .o_victim (w_plru_victim)
  );

  // NOTE: line and tag storage has no reset; the valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    if (w_hit_resp && mem_write)
      r_data[w_hit_way][w_index][{w_off, 4'h0} +: 16] <= w_merged;
    if (w_fill_done) begin
      r_data[r_victim][w_r_idx] <= pmem_rdata;
      r_tag[r_victim][w_r_idx]  <= w_r_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
    end else begin
      if (w_hit_resp && mem_write) r_dirty[w_hit_way][w_index] <= 1'b1;
      if (w_fill_done) begin
        r_valid[r_victim][w_r_idx] <= 1'b1;
        r_dirty[r_victim][w_r_idx] <= 1'b0;
      end
    end
  end

  // Victim and line address are frozen at miss detection; inputs are ignored until IDLE again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_victim <= '0;
      r_line   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_miss) begin
        r_victim <= w_victim_sel;
        r_line   <= mem_address[15:4];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {r_line, 4'h0};
    case (r_state)
      IDLE: if (w_miss) w_state_nxt = w_victim_dirty ? WRITEBACK : FILL;
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[r_victim][w_r_idx], w_r_idx, 4'h0};
        if (pmem_resp) w_state_nxt = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic [15:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;
  logic        w_wb_done;

  assign w_wb_done = (r_state == WRITEBACK) && pmem_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_hit_resp && r_hit_cnt  != 16'hFFFF) r_hit_cnt  <= r_hit_cnt  + 16'd1;
      if (w_miss     && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
      if (w_wb_done  && r_wb_cnt   != 16'hFFFF) r_wb_cnt   <= r_wb_cnt   + 16'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
  assign wb_count   = r_wb_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Directed self-checking bench for cache_nway (WAYS=4, SETS=8) with a fixed-latency memory model.
module tb_cache_nway;
  import lc3b_types::*;

  localparam int MEM_LAT = 2;

`ifdef CACHE_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_address;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_resp;
  logic [15:0] pmem_address;
  logic        pmem_read, pmem_write;
  lc3b_cline   pmem_rdata, pmem_wdata;
  logic        pmem_resp;
  logic [15:0] hit_count, miss_count, wb_count;

  cache_nway #(.WAYS(4), .SETS(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_rdata      (pmem_rdata),
    .pmem_wdata      (pmem_wdata),
    .pmem_resp       (pmem_resp),
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .wb_count        (wb_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [15:0] t_rdata, t_wb_addr, t_fill_addr;
  lc3b_cline   t_wb_data;
  int          t_cycles;
  logic        t_done, t_wb_seen, t_fill_seen, t_fill_first, t_both;

  // Memory contents: each word holds its own byte address (LSB cleared).
  function automatic lc3b_cline mem_line(input logic [15:0] a);
    lc3b_cline l;
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = {a[15:4], 3'(k), 1'b0};
    return l;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU access held until mem_resp; logs memory-side activity and answers it after MEM_LAT cycles.
  task automatic access(input logic [15:0] a, input logic rd, input logic wr,
                        input logic [1:0] be, input logic [15:0] wd);
    int busy;
    busy = 0;
    t_done = 1'b0; t_wb_seen = 1'b0; t_fill_seen = 1'b0; t_fill_first = 1'b0; t_both = 1'b0;
    t_cycles = -1; t_rdata = '0; t_wb_addr = '0; t_fill_addr = '0; t_wb_data = '0;
    @(negedge clk);
    mem_address = a; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
    #1;
    for (int i = 0; i < 100 && !t_done; i++) begin
      if (mem_resp) begin
        t_done   = 1'b1;
        t_rdata  = mem_rdata;
        t_cycles = i;
      end
      if (pmem_read && pmem_write) t_both = 1'b1;
      if (pmem_write && !t_wb_seen) begin
        t_wb_seen = 1'b1;
        t_wb_addr = pmem_address;
        t_wb_data = pmem_wdata;
      end
      if (pmem_read && !t_fill_seen) begin
        t_fill_seen  = 1'b1;
        t_fill_addr  = pmem_address;
        t_fill_first = !t_wb_seen;
      end
      if (pmem_read || pmem_write) begin
        busy++;
        if (busy == MEM_LAT) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_line(pmem_address);
          busy       = 0;
        end
      end
      @(posedge clk); #1;
      pmem_resp = 1'b0;
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    lc3b_cline exp_wb;
    rst_n = 1'b0;
    mem_address = 16'h1234; mem_read = 1'b1; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;

    // Reset: a pending request must not produce any handshake.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_resp",   mem_resp,   1'b0);
    check("rst_pmem_read",  pmem_read,  1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_hit_count",  hit_count,  16'd0);
    check("rst_miss_count", miss_count, 16'd0);
    mem_read = 1'b0;
    rst_n = 1'b1;

    // Cold read miss fills way 0 of index 3; retry returns word 2.
    access(16'h1234, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("miss_done",      t_done,      1'b1);
    check("miss_fill_seen", t_fill_seen, 1'b1);
    check("miss_fill_addr", t_fill_addr, 16'h1230);
    check("miss_no_wb",     t_wb_seen,   1'b0);
    check("miss_rdata",     t_rdata,     16'h1234);
    check("miss_latency",   t_cycles,    MEM_LAT + 1);

    // Write hit with low-byte mask.
    access(16'h1236, 1'b0, 1'b1, 2'b01, 16'hBEEF);
    check("whit_done",    t_done,      1'b1);
    check("whit_same_cy", t_cycles,    0);
    check("whit_no_fill", t_fill_seen, 1'b0);

    // Second miss into way 1; counters now at 3 hits and 2 misses.
    access(16'h12B2, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("way1_rdata", t_rdata, 16'h12B2);
    check("cnt_hit_3",  hit_count,  CNT_ON ? 16'd3 : 16'd0);
    check("cnt_miss_2", miss_count, CNT_ON ? 16'd2 : 16'd0);

    access(16'h1332, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("way2_rdata", t_rdata, 16'h1332);
    access(16'h13B2, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("way3_rdata", t_rdata, 16'h13B2);

    // Touch ways 0,1,2,3 in order; way 0 shows the merged byte.
    access(16'h1236, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("merge_rdata", t_rdata,  16'h12EF);
    check("merge_hit",   t_cycles, 0);
    access(16'h12B0, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("w1_hit", t_cycles, 0);
    access(16'h1330, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("w2_hit", t_cycles, 0);
    access(16'h13B0, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("w3_hit", t_cycles, 0);

    // Fifth tag in index 3: PLRU picks dirty way 0, writeback precedes fill.
    access(16'h1434, 1'b1, 1'b0, 2'b00, 16'h0000);
    exp_wb = mem_line(16'h1230);
    exp_wb[3*16 +: 16] = 16'h12EF;
    check("evict_done",       t_done,       1'b1);
    check("evict_wb_seen",    t_wb_seen,    1'b1);
    check("evict_wb_addr",    t_wb_addr,    16'h1230);
    check("evict_wb_data",    t_wb_data,    exp_wb);
    check("evict_wb_first",   t_fill_first, 1'b0);
    check("evict_fill_addr",  t_fill_addr,  16'h1430);
    check("evict_no_overlap", t_both,       1'b0);
    check("evict_rdata",      t_rdata,      16'h1434);
    check("evict_latency",    t_cycles,     2 * MEM_LAT + 1);
    check("cnt_hit_10", hit_count,  CNT_ON ? 16'd10 : 16'd0);
    check("cnt_miss_5", miss_count, CNT_ON ? 16'd5  : 16'd0);
    check("cnt_wb_1",   wb_count,   CNT_ON ? 16'd1  : 16'd0);

    // Reset in the middle of a fill.
    @(negedge clk);
    mem_address = 16'h5678; mem_read = 1'b1;
    #1;
    @(posedge clk); #1;
    check("midfill_pmem_read", pmem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midfill_rst_drop",  pmem_read,  1'b0);
    check("midfill_rst_resp",  mem_resp,   1'b0);
    check("midfill_rst_hits",  hit_count,  16'd0);
    check("midfill_rst_wbcnt", wb_count,   16'd0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    access(16'h5678, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("refetch_fill_seen", t_fill_seen, 1'b1);
    check("refetch_fill_addr", t_fill_addr, 16'h5670);
    check("refetch_rdata",     t_rdata,     16'h5678);

    // Read and write together behave as a write.
    access(16'h567A, 1'b1, 1'b1, 2'b11, 16'hA5A5);
    check("rw_hit", t_cycles, 0);
    access(16'h567A, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("rw_rdata", t_rdata, 16'hA5A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
